// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder (two half adders + OR) stepped
// LSB-first over WIDTH cycles behind a start/busy/done handshake.

module halfadd (
   input  logic a,
   input  logic b,
   output logic s,
   output logic c
);
   assign s = a ^ b;
   assign c = a & b;
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, s_q, s_d;
   logic             cy_q, cy_d, c_q, c_d;
   logic             s1, c1, sum_bit, c2;

   halfadd u_ha0 (.a(a_q[0]), .b(b_q[0]), .s(s1),      .c(c1));
   halfadd u_ha1 (.a(s1),     .b(cy_q),   .s(sum_bit), .c(c2));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      cy_d    = cy_q;
      res_d   = res_q;
      s_d     = s_q;
      c_d     = c_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               a_d     = in1;
               b_d     = in2;
               cy_d    = cin;
               cnt_d   = '0;
               res_d   = '0;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            cy_d  = c1 | c2;
            // sum bits enter at the MSB so bit 0 lands in place after WIDTH shifts
            res_d = (res_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = DONE;
               s_d     = res_d;
               c_d     = c1 | c2;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cy_q    <= 1'b0;
         res_q   <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cy_q    <= cy_d;
         res_q   <= res_d;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);
   assign s    = s_q;
   assign c    = c_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 directed ops plus a WIDTH=4 exhaustive
// back-to-back sweep, checked through per-instance result scoreboards.

module tb_serial_add_ctrl;
   logic       clk, rst;
   logic       start8, cin8, busy8, done8, c8;
   logic [7:0] in1_8, in2_8, s8;
   logic       start4, cin4, busy4, done4, c4;
   logic [3:0] in1_4, in2_4, s4;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int last4   = -1;
   logic [8:0] q8[$];
   logic [4:0] q4[$];
   logic [7:0] last8_s = '0;

   serial_add_ctrl #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .in1(in1_8), .in2(in2_8), .cin(cin8),
      .busy(busy8), .done(done8), .s(s8), .c(c8));

   serial_add_ctrl #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .in1(in1_4), .in2(in2_4), .cin(cin4),
      .busy(busy4), .done(done4), .s(s4), .c(c4));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done8 === 1'b1) begin
         if (q8.size() == 0) chk("done8_extra", 1, 0);
         else chk("sum8", {23'd0, c8, s8}, {23'd0, q8.pop_front()});
      end
      if (done4 === 1'b1) begin
         if (q4.size() == 0) chk("done4_extra", 1, 0);
         else chk("sum4", {27'd0, c4, s4}, {27'd0, q4.pop_front()});
         if (last4 >= 0) chk("spacing4", cyc - last4, 6);
         last4 = cyc;
      end
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, input bit inject);
      int nb;
      logic [8:0] e;
      e = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      @(negedge clk);
      in1_8 = a; in2_8 = b; cin8 = ci; start8 = 1'b1;
      q8.push_back(e);
      @(negedge clk);
      start8 = 1'b0;
      in1_8 = 8'($urandom); in2_8 = 8'($urandom); cin8 = 1'($urandom);
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (busy8) nb++;
         if (inject && (i == 1 || i == 4)) begin
            start8 = 1'b1; in1_8 = 8'hAA; in2_8 = 8'hAA;
         end else start8 = 1'b0;
         if (i == 3) chk("s_hold", {24'd0, s8}, {24'd0, last8_s});
         @(negedge clk);
      end
      start8 = 1'b0;
      chk("busy_cycles", nb, 8);
      chk("done_pulse", {31'd0, done8}, 1);
      last8_s = e[7:0];
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done8}, 0);
   endtask

   initial begin
      rst = 1'b1;
      start8 = 1'b1; in1_8 = 8'($urandom); in2_8 = 8'($urandom); cin8 = 1'($urandom);
      start4 = 1'b1; in1_4 = 4'($urandom); in2_4 = 4'($urandom); cin4 = 1'($urandom);
      #1;
      chk("rst_busy8", {31'd0, busy8}, 0);
      chk("rst_done8", {31'd0, done8}, 0);
      chk("rst_s8",    {24'd0, s8}, 0);
      chk("rst_c8",    {31'd0, c8}, 0);
      chk("rst_busy4", {31'd0, busy4}, 0);
      chk("rst_s4",    {28'd0, s4}, 0);
      start8 = 1'b0; start4 = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;

      op8(8'h0F, 8'h01, 1'b0, 1'b0);
      op8(8'hFF, 8'h01, 1'b0, 1'b0);
      op8(8'hFF, 8'hFF, 1'b1, 1'b0);
      op8(8'h12, 8'h34, 1'b0, 1'b1);

      // abandoned op: nothing pushed, so any done pulse is flagged as extra
      @(negedge clk);
      in1_8 = 8'hF0; in2_8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      chk("midop_busy", {31'd0, busy8}, 1);
      rst = 1'b1;
      #1;
      chk("midrst_busy", {31'd0, busy8}, 0);
      chk("midrst_done", {31'd0, done8}, 0);
      chk("midrst_s",    {24'd0, s8}, 0);
      chk("midrst_c",    {31'd0, c8}, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      last8_s = '0;
      repeat (10) @(negedge clk);
      op8(8'h01, 8'h01, 1'b0, 1'b0);

      start4 = 1'b1;
      for (int a = 0; a < 16; a++)
         for (int b = 0; b < 16; b++)
            for (int ci = 0; ci < 2; ci++) begin
               int k;
               k = 0;
               while ((busy4 || done4) && k < 20) begin
                  @(negedge clk);
                  k++;
               end
               if (k >= 20) chk("idle4_timeout", 0, 1);
               in1_4 = 4'(a); in2_4 = 4'(b); cin4 = 1'(ci);
               q4.push_back(5'(a) + 5'(b) + 5'(ci));
               @(negedge clk);
            end
      start4 = 1'b0;

      for (int k = 0; k < 50 && (q8.size() != 0 || q4.size() != 0); k++) @(negedge clk);
      chk("drain8", q8.size(), 0);
      chk("drain4", q4.size(), 0);
      repeat (10) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
